// File: rtl/digit_serial_sub.sv
// Digit-serial borrow-chain subtractor: diff = a - b - bin, DIGIT bits per clock, LSB slice first.
// Optional macro SUB_SAT_EN: floor diff at zero whenever the final borrow is set.

module digit_serial_sub_slice #(
    parameter int DIGIT = 3
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);
    always_comb begin : chain
        logic br;
        br = bin;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end
endmodule

module digit_serial_sub #(
    parameter int WIDTH = 12,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [IDXW-1:0]  idx;
    logic             br;
    logic [WIDTH-1:0] a_q, b_q, res, res_next, diff_load;
    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic             br_out;
    logic             last;

    assign last  = (idx == LAST);
    assign a_dig = a_q[idx*DIGIT +: DIGIT];
    assign b_dig = b_q[idx*DIGIT +: DIGIT];

    digit_serial_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_dig),
        .b    (b_dig),
        .bin  (br),
        .d    (d_dig),
        .bout (br_out)
    );

    always_comb begin
        res_next = res;
        res_next[idx*DIGIT +: DIGIT] = d_dig;
    end

`ifdef SUB_SAT_EN
    assign diff_load = br_out ? '0 : res_next;
`else
    assign diff_load = res_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Handshake outputs decode straight from the state register, so they never see out_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: if (last) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            res  <= '0;
            br   <= 1'b0;
            idx  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                    br  <= bin;
                    idx <= '0;
                end
                RUN: begin
                    res <= res_next;
                    br  <= br_out;
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        diff <= diff_load;
                        bout <= br_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_sub.sv
// Randomised self-checking bench for digit_serial_sub against an arithmetic reference model.
// Honours SUB_SAT_EN in the model when the same macro is defined for the build.

module tb_digit_serial_sub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, bin_i = 1'b0;
    logic [11:0] a_i = '0, b_i = '0;
    logic        in_ready, out_valid, bout;
    logic [11:0] diff;

    logic       iv6 = 1'b0, bn6 = 1'b0;
    logic [5:0] a6 = '0, b6 = '0, d6;
    logic       ir6, ov6, bo6;
    logic       iv8 = 1'b0, bn8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       ir8, ov8, bo8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    digit_serial_sub dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .bin(bin_i), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
    );

    digit_serial_sub #(.WIDTH(6), .DIGIT(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6),
        .a(a6), .b(b6), .bin(bn6), .out_valid(ov6), .out_ready(out_ready),
        .diff(d6), .bout(bo6)
    );

    digit_serial_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bn8), .out_valid(ov8), .out_ready(out_ready),
        .diff(d8), .bout(bo8)
    );

    // Reference: plain integer subtraction, wrap to w bits, borrow = result went negative.
    function automatic void model(input int w, input int av, input int bv, input bit bi,
                                  output logic [15:0] d, output bit bo);
        int r;
        r  = av - bv - int'(bi);
        bo = (r < 0);
        d  = 16'(r & ((1 << w) - 1));
`ifdef SUB_SAT_EN
        if (bo) d = '0;
`endif
    endfunction

    task automatic issue(input logic [11:0] av, input logic [11:0] bv, input logic bi);
        @(negedge clk);
        a_i = av; b_i = bv; bin_i = bi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) n = -1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (diff !== 12'h000)   begin miscompares++; $display("FAIL reset_diff: got %h want 000", diff); end
        if (bout !== 1'b0)      begin miscompares++; $display("FAIL reset_bout: got %b want 0", bout); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        out_ready = 1'b1;
        issue(12'h123, 12'h023, 1'b0);
        wait_out(n);
        vectors += 5;
        if (n != 4)           begin miscompares++; $display("FAIL basic_latency: got %0d want 4", n); end
        if (diff !== 12'h100) begin miscompares++; $display("FAIL basic_diff: got %h want 100", diff); end
        if (bout !== 1'b0)    begin miscompares++; $display("FAIL basic_bout: got %b want 0", bout); end
        @(negedge clk);
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_width: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL basic_in_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_borrow_chain;
        logic [11:0] ta [2] = '{12'h800, 12'h000};
        logic [11:0] tb [2] = '{12'h7FF, 12'h001};
        logic        tbi[2] = '{1'b1, 1'b0};
        logic [11:0] ted[2];
        logic        teb[2] = '{1'b0, 1'b1};
        int n;
        ted[0] = 12'h000;
`ifdef SUB_SAT_EN
        ted[1] = 12'h000;
`else
        ted[1] = 12'hFFF;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], tbi[i]);
            wait_out(n);
            vectors += 3;
            if (n != 4)          begin miscompares++; $display("FAIL chain%0d_latency: got %0d want 4", i, n); end
            if (diff !== ted[i]) begin miscompares++; $display("FAIL chain%0d_diff: got %h want %h", i, diff, ted[i]); end
            if (bout !== teb[i]) begin miscompares++; $display("FAIL chain%0d_bout: got %b want %b", i, bout, teb[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic [15:0] e1, e2;
        bit b1, b2;
        model(12, 'h5A5, 'h1C3, 1'b1, e1, b1);
        model(12, 'h0F0, 'h3F1, 1'b0, e2, b2);
        out_ready = 1'b0;
        issue(12'h5A5, 12'h1C3, 1'b1);
        wait_out(n);
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL bp_latency: got %0d want 4", n); end
        a_i = 12'h0F0; b_i = 12'h3F1; bin_i = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors += 4;
            if (out_valid !== 1'b1)  begin miscompares++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
            if (in_ready !== 1'b0)   begin miscompares++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            if (diff !== e1[11:0])   begin miscompares++; $display("FAIL bp_diff%0d: got %h want %h", i, diff, e1[11:0]); end
            if (bout !== b1)         begin miscompares++; $display("FAIL bp_bout%0d: got %b want %b", i, bout, b1); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_next: got %b want 0", in_ready); end
        wait_out(n);
        vectors += 3;
        if (n != 4)            begin miscompares++; $display("FAIL bp2_latency: got %0d want 4", n); end
        if (diff !== e2[11:0]) begin miscompares++; $display("FAIL bp2_diff: got %h want %h", diff, e2[11:0]); end
        if (bout !== b2)       begin miscompares++; $display("FAIL bp2_bout: got %b want %b", bout, b2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        out_ready = 1'b1;
        issue(12'h777, 12'h111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_run_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_run_ready: got %b want 1", in_ready); end
        if (diff !== 12'h000)   begin miscompares++; $display("FAIL rst_run_diff: got %h want 000", diff); end
        if (bout !== 1'b0)      begin miscompares++; $display("FAIL rst_run_bout: got %b want 0", bout); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL rst_run_ghost: got result want none"); end
    endtask

    task automatic test_random;
        int n, k;
        logic [11:0] av, bv;
        logic bi;
        logic [15:0] ed;
        bit eb, stable;
        for (int t = 0; t < 1000; t++) begin
            av = 12'($urandom); bv = 12'($urandom); bi = 1'($urandom);
            model(12, int'(av), int'(bv), bi, ed, eb);
            out_ready = 1'($urandom);
            issue(av, bv, bi);
            wait_out(n);
            vectors += 3;
            if (n != 4)            begin miscompares++; if (miscompares < 20) $display("FAIL rnd%0d_latency: got %0d want 4", t, n); end
            if (diff !== ed[11:0]) begin miscompares++; if (miscompares < 20) $display("FAIL rnd%0d_diff: got %h want %h", t, diff, ed[11:0]); end
            if (bout !== eb)       begin miscompares++; if (miscompares < 20) $display("FAIL rnd%0d_bout: got %b want %b", t, bout, eb); end
            if (out_ready == 1'b0) begin
                k = $urandom_range(0, 3);
                stable = 1'b1;
                for (int s = 0; s < k; s++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || diff !== ed[11:0] || bout !== eb) stable = 1'b0;
                end
                vectors++;
                if (!stable) begin miscompares++; if (miscompares < 20) $display("FAIL rnd%0d_stall: got unstable want held", t); end
                out_ready = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; if (miscompares < 20) $display("FAIL rnd%0d_dup: got %b want 0", t, out_valid); end
        end
    endtask

    task automatic test_sweep;
        int n;
        logic [15:0] ed;
        bit eb;
        out_ready = 1'b1;
        for (int av = 0; av < 64; av++)
            for (int bv = 0; bv < 64; bv++)
                for (int bi = 0; bi < 2; bi++) begin
                    model(6, av, bv, bit'(bi), ed, eb);
                    @(negedge clk);
                    a6 = 6'(av); b6 = 6'(bv); bn6 = 1'(bi); iv6 = 1'b1;
                    @(negedge clk);
                    iv6 = 1'b0;
                    n = 0;
                    while (ov6 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                    vectors += 3;
                    if (n != 2)         begin miscompares++; if (miscompares < 20) $display("FAIL w6_latency %0d-%0d-%0d: got %0d want 2", av, bv, bi, n); end
                    if (d6 !== ed[5:0]) begin miscompares++; if (miscompares < 20) $display("FAIL w6_diff %0d-%0d-%0d: got %h want %h", av, bv, bi, d6, ed[5:0]); end
                    if (bo6 !== eb)     begin miscompares++; if (miscompares < 20) $display("FAIL w6_bout %0d-%0d-%0d: got %b want %b", av, bv, bi, bo6, eb); end
                end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); bn8 = 1'($urandom); iv8 = 1'b1;
            model(8, int'(a8), int'(b8), bn8, ed, eb);
            @(negedge clk);
            iv8 = 1'b0;
            n = 0;
            while (ov8 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            vectors += 3;
            if (n != 8)         begin miscompares++; if (miscompares < 20) $display("FAIL w8_latency%0d: got %0d want 8", t, n); end
            if (d8 !== ed[7:0]) begin miscompares++; if (miscompares < 20) $display("FAIL w8_diff%0d: got %h want %h", t, d8, ed[7:0]); end
            if (bo8 !== eb)     begin miscompares++; if (miscompares < 20) $display("FAIL w8_bout%0d: got %b want %b", t, bo8, eb); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_chain();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/digit_serial_sub.md
# digit_serial_sub

Digit-serial borrow-chain subtractor: computes diff = a − b − bin over WIDTH-bit operands, one DIGIT-bit slice per clock, LSB slice first. It is the inverse companion of the combinational 3-bit ripple-carry adder slices. It recovers one operand from a sum and the other operand, and it reuses the same per-slice bit structure, here registered and time-multiplexed. Operands arrive through a valid/ready input handshake. The result is held on a valid/ready output handshake until it is consumed.

## Interface
- WIDTH, 12, operand/result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 3, bits processed per cycle.
- NDIG (derived, not overridable), WIDTH/DIGIT, number of slice cycles.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  diff/bout valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  out  1  final borrow out; 1 means a < b + bin.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: slice processing.
  - DONE: out_valid=1.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, slice index=0, internal borrow=0, operand/shift registers=0.
- IDLE:
  - On in_valid&in_ready, capture a, b and bin (bin becomes the running borrow), clear the index, go to RUN.
  - in_valid is ignored in all other states.
- RUN:
  - Each edge processes slice k = index.
  - Bits [k·DIGIT +: DIGIT] are computed with a bitwise ripple borrow chain: d_i = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - The slice result goes into the internal result register; the slice's final borrow is stored as the running borrow; index increments.
  - The edge that processes slice NDIG−1 moves to DONE and loads diff and bout from the completed result.
- DONE:
  - diff and bout hold stable while out_valid=1.
  - On out_valid&out_ready, go to IDLE.
- diff and bout change only on entry to DONE. They keep their last value in IDLE and RUN, and are 0 after reset.
- Arithmetic: result bits are exact modulo 2^WIDTH, and bout equals the borrow out of bit WIDTH−1. There are no other flags.
- Reset mid-operation (any state) aborts immediately with the reset values above. No partial result is ever presented.

## Timing
- Edge E0 accepts the operands (in_valid&in_ready).
- Edges E1..E_NDIG process slices 0..NDIG−1.
- out_valid rises after E_NDIG. Latency is NDIG edges from acceptance (4 at defaults).
- Output transfer at edge Ex (out_valid&out_ready):
  - After Ex, out_valid=0 and in_ready=1.
  - The next operand can be accepted at Ex+1.
- Minimum spacing between acceptances is NDIG+2 edges.
- in_ready never depends combinationally on out_ready.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- SUB_SAT_EN defined:
  - When the final borrow is 1, diff is loaded with 0 on entry to DONE, giving an unsigned floor at zero.
  - bout is still reported as 1.
- SUB_SAT_EN undefined: diff is the wrapped modulo result; no saturation logic is present.

## Test plan
- Basic: a=0x123, b=0x023, bin=0, out_ready=1. Required: diff=0x100, bout=0; out_valid rises exactly 4 edges after acceptance and lasts 1 cycle; in_ready returns 1 the next cycle.
- Borrow chain: a=0x800, b=0x7FF, bin=1. Required: diff=0x000, bout=0. Then a=0x000, b=0x001, bin=0. Required: diff=0xFFF, bout=1 without SUB_SAT_EN; diff=0x000, bout=1 with it.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles after out_valid; meanwhile in_valid=1 with new operands.
  - Required: diff/bout stable, in_ready=0, new operands not captured.
  - After out_ready=1, the new operands are accepted one edge after the transfer.
- Reset mid-RUN: deassert rst_n two edges after acceptance. Required: out_valid=0, in_ready=1, diff=0, bout=0 immediately; no result appears after release.
- Random back-to-back: 1000 random a, b, bin with random out_ready stalls. Required: every result equals the reference model a−b−bin (mod 2^12, borrow); no result is dropped or duplicated.
- Parameter sweep: WIDTH=6, DIGIT=3 and WIDTH=8, DIGIT=1. Required: latency equals NDIG (2 and 8), with exhaustive-correct results for WIDTH=6.
